// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I datapath: sequences fetch/decode/execute/memory/writeback
// over one shared memory port and ALU, driving every select and write enable.
module multicycle_controller #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic       Retired,
    output logic       Illegal
);

    // state    | meaning
    // FETCH    | read instruction at PC, PC <= PC + 4 when memory is ready
    // DECODE   | read registers, branch target into ALUOut
    // MEMADR   | compute load/store address
    // MEMREAD  | load access, waits on MemReady
    // MEMWB    | write loaded data to register file
    // MEMWRITE | store access, strobe held until MemReady
    // EXECR    | register-register ALU operation
    // EXECI    | register-immediate ALU operation
    // ALUWB    | write ALUOut to register file
    // JAL      | PC <= branch target, link address into ALUOut
    // BEQ      | compare operands, take branch on Zero
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    typedef struct packed {
        logic       adr_src;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       mem_write;
        logic       reg_write;
        logic       pc_update;
        logic       branch;
        logic       retired;
    } ctrl_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    function automatic ctrl_t moore_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEMREAD:  c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
                c.retired    = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_EXECI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.retired   = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_update = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
                c.branch    = 1'b1;
                c.retired   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t state_q, state_d;
    ctrl_t  ctrl_q;
    logic   mem_rdy;
    logic   op_legal;
    logic   in_fetch;
    logic   pc_update;
    logic [2:0] alu_ctrl;
    logic [1:0] imm_src;

    assign mem_rdy  = MEM_WAIT_EN ? MemReady : 1'b1;
    assign in_fetch = (state_q == S_FETCH);
    assign op_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                      (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_rdy ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore fields are registered from the next state so they are glitch-free in the new state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= moore_ctrl(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= moore_ctrl(state_d);
        end
    end

    always_comb begin
        alu_ctrl = 3'b000;
        case (ctrl_q.alu_op)
            2'b01: alu_ctrl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  alu_ctrl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_ctrl = 3'b101;
                    3'b110:  alu_ctrl = 3'b011;
                    3'b111:  alu_ctrl = 3'b010;
                    default: alu_ctrl = 3'b000;
                endcase
            end
            default: alu_ctrl = 3'b000;
        endcase
    end

    always_comb begin
        imm_src = 2'b00;
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    // Every output is qualified by reset so assertion clears it without waiting for a clock edge.
    assign pc_update  = (in_fetch & mem_rdy) | ctrl_q.pc_update;
    assign PCWrite    = reset & (pc_update | (ctrl_q.branch & Zero));
    assign IRWrite    = reset & in_fetch & mem_rdy;
    assign AdrSrc     = reset & ctrl_q.adr_src;
    assign MemWrite   = reset & ctrl_q.mem_write;
    assign RegWrite   = reset & ctrl_q.reg_write;
    assign Retired    = reset & (ctrl_q.retired | ((state_q == S_MEMWRITE) & mem_rdy));
    assign Illegal    = reset & (state_q == S_DECODE) & ~op_legal;
    assign ResultSrc  = reset ? ctrl_q.result_src : 2'b00;
    assign ALUSrcA    = reset ? ctrl_q.alu_src_a  : 2'b00;
    assign ALUSrcB    = reset ? ctrl_q.alu_src_b  : 2'b00;
    assign ImmSrc     = reset ? imm_src           : 2'b00;
    assign ALUControl = reset ? alu_ctrl          : 3'b000;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: runs each instruction class from FETCH to the next
// FETCH and checks per-cycle controls against hand-derived values.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Retired, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    multicycle_controller #(.MEM_WAIT_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .RegWrite(RegWrite),
        .Retired(Retired), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam int MAXC = 20;

    int n_checks = 0;
    int n_errors = 0;
    int len;
    int rw [MAXC];
    int rs [MAXC];
    int ret[MAXC];
    int pcw[MAXC];
    int aluc[MAXC];
    int ill[MAXC];
    int imm[MAXC];
    int rw_n, ret_n, mw_n, ill_n;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                     ImmSrc, ALUControl, RegWrite, Retired, Illegal});
    endfunction

    // Runs one instruction starting in FETCH; MemReady is low for cycles [st, st+ns).
    task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input int st, input int ns);
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        len = MAXC; rw_n = 0; ret_n = 0; mw_n = 0; ill_n = 0;
        for (int c = 0; c < MAXC; c++) begin
            MemReady = (c >= st && c < st + ns) ? 1'b0 : 1'b1;
            #1;
            rw[c]   = int'(RegWrite);
            rs[c]   = int'(ResultSrc);
            ret[c]  = int'(Retired);
            pcw[c]  = int'(PCWrite);
            aluc[c] = int'(ALUControl);
            ill[c]  = int'(Illegal);
            imm[c]  = int'(ImmSrc);
            if (c > 0 && ALUSrcB == 2'b10 && ResultSrc == 2'b10 &&
                ALUSrcA == 2'b00 && AdrSrc == 1'b0) begin
                len = c;
                break;
            end
            rw_n  += int'(RegWrite);
            ret_n += int'(Retired);
            mw_n  += int'(MemWrite);
            ill_n += int'(Illegal);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b0; MemReady = 1'b1; op = OP_SW; funct3 = 3'b000;
        funct7b5 = 1'b1; Zero = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", all_outs(), 0);
        reset = 1'b1;
        #1;
        chk("fetch_irwrite", int'(IRWrite), 1);
        chk("fetch_pcwrite", int'(PCWrite), 1);
        chk("fetch_alusrcb", int'(ALUSrcB), 2);
        chk("fetch_resultsrc", int'(ResultSrc), 2);

        run(OP_LW, 3'b010, 1'b0, 1'b0, 3, 2);
        chk("lw_len", len, 7);
        chk("lw_rw_n", rw_n, 1);
        chk("lw_rw6", rw[6], 1);
        chk("lw_rs6", rs[6], 1);
        chk("lw_ret_n", ret_n, 1);

        run(OP_R, 3'b000, 1'b1, 1'b0, 1, 2);
        chk("sub_len", len, 4);
        chk("sub_aluc", aluc[2], 1);
        chk("sub_rw3", rw[3], 1);
        chk("sub_rw_n", rw_n, 1);

        run(OP_R, 3'b000, 1'b0, 1'b0, 99, 0);
        chk("add_aluc", aluc[2], 0);
        run(OP_R, 3'b010, 1'b0, 1'b0, 99, 0);
        chk("slt_aluc", aluc[2], 5);
        run(OP_R, 3'b111, 1'b0, 1'b0, 99, 0);
        chk("and_aluc", aluc[2], 2);

        run(OP_I, 3'b000, 1'b1, 1'b0, 99, 0);
        chk("addi_len", len, 4);
        chk("addi_aluc", aluc[2], 0);
        chk("addi_imm", imm[1], 0);
        run(OP_I, 3'b110, 1'b0, 1'b0, 99, 0);
        chk("ori_aluc", aluc[2], 3);

        run(OP_BEQ, 3'b000, 1'b0, 1'b1, 99, 0);
        chk("beq_t_len", len, 3);
        chk("beq_t_pcw", pcw[2], 1);
        chk("beq_t_aluc", aluc[2], 1);
        chk("beq_t_ret", ret[2], 1);
        chk("beq_imm", imm[1], 2);
        run(OP_BEQ, 3'b000, 1'b0, 1'b0, 99, 0);
        chk("beq_nt_pcw", pcw[2], 0);
        chk("beq_nt_aluc", aluc[2], 1);
        chk("beq_nt_ret", ret[2], 1);

        run(OP_JAL, 3'b000, 1'b0, 1'b0, 99, 0);
        chk("jal_len", len, 4);
        chk("jal_imm", imm[1], 3);
        chk("jal_pcw", pcw[2], 1);
        chk("jal_rw3", rw[3], 1);
        chk("jal_rs3", rs[3], 0);

        run(7'b0000000, 3'b000, 1'b0, 1'b0, 99, 0);
        chk("ill_len", len, 2);
        chk("ill_pulse", ill[1], 1);
        chk("ill_n", ill_n, 1);
        chk("ill_no_wr", rw_n + mw_n, 0);

        run(OP_SW, 3'b010, 1'b0, 1'b0, 99, 0);
        chk("sw_len", len, 4);
        chk("sw_mw_n", mw_n, 1);
        chk("sw_ret_n", ret_n, 1);
        chk("sw_imm", imm[0], 1);

        // sw stalled in MEMWRITE, then reset asserted between clock edges
        op = OP_SW; MemReady = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        MemReady = 1'b0;
        #1;
        chk("sws_mw", int'(MemWrite), 1);
        @(posedge clk); #2;
        chk("sws_mw_held", int'(MemWrite), 1);
        chk("sws_ret", int'(Retired), 0);
        reset = 1'b0;
        #1;
        chk("sws_rst_mw", int'(MemWrite), 0);
        chk("sws_rst_outs", all_outs(), 0);
        MemReady = 1'b1;
        reset = 1'b1;
        #1;
        chk("rec_irwrite", int'(IRWrite), 1);

        run(OP_LW, 3'b010, 1'b0, 1'b0, 99, 0);
        chk("lw2_len", len, 5);
        chk("lw2_rw4", rw[4], 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
